// File: rtl/bht_access_ctrl.sv
// rtl/bht_access_ctrl.sv - BHT RAM owner: init sweep, lookup/update arbitration, RMW counter updates

// Small circular queue holding resolved-branch updates until the table is free.
module bht_upd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_tvalid,
  input  logic [W-1:0] s_tdata,
  output logic         s_tready,
  output logic         m_tvalid,
  output logic [W-1:0] m_tdata,
  input  logic         m_tready,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign s_tready = rst_n && !full;
  assign m_tvalid = (count != '0);
  assign m_tdata  = mem[rd_ptr];
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tready && m_tvalid;

  // Pointer and occupancy tracking; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Entry storage needs no reset: only slots below count are ever presented.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_tdata;
  end
endmodule

module bht_access_ctrl #(
  parameter int N            = 32,
  parameter int INDEX_WIDTH  = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_lkp_valid,
  input  logic [N-1:0]           i_lkp_pc,
  output logic                   o_lkp_ready,
  output logic                   o_lkp_rvalid,
  output logic                   o_lkp_taken,
  output logic [N-1:0]           o_lkp_target,
  input  logic                   i_upd_valid,
  input  logic [N-1:0]           i_upd_pc,
  input  logic [N-1:0]           i_upd_target,
  input  logic                   i_upd_taken,
  output logic                   o_upd_ready,
  output logic                   o_init_busy,
  output logic                   o_tbl_en,
  output logic                   o_tbl_we,
  output logic [INDEX_WIDTH-1:0] o_tbl_addr,
  output logic [N-1:0]           o_tbl_wtag,
  output logic [N-1:0]           o_tbl_wtarget,
  output logic [1:0]             o_tbl_wctr,
  input  logic [N-1:0]           i_tbl_rtag,
  input  logic [N-1:0]           i_tbl_rtarget,
  input  logic [1:0]             i_tbl_rctr
);
  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_UPD_RD = 2'd2;
  localparam logic [1:0] ST_UPD_WR = 2'd3;

  localparam int IW = INDEX_WIDTH;
  localparam int UW = 2 * N + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [IW-1:0] init_idx;
  logic [SW-1:0] starve_cnt;

  logic          fifo_nonempty;
  logic          fifo_full;
  logic [UW-1:0] head;
  logic [N-1:0]  head_pc;
  logic [N-1:0]  head_target;
  logic          head_taken;

  logic          upd_win;
  logic          lkp_grant;
  logic          upd_hit;
  logic [1:0]    new_ctr;
  logic [N-1:0]  new_target;

  logic          rvalid_q;
  logic [N-1:0]  pc_q;

  assign {head_pc, head_target, head_taken} = head;

  bht_upd_fifo #(
    .W     (UW),
    .DEPTH (FIFO_DEPTH)
  ) u_upd_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tvalid (i_upd_valid),
    .s_tdata  ({i_upd_pc, i_upd_target, i_upd_taken}),
    .s_tready (o_upd_ready),
    .m_tvalid (fifo_nonempty),
    .m_tdata  (head),
    .m_tready (rst_n && (state == ST_UPD_WR)),
    .full     (fifo_full)
  );

  // An update takes the table when the queue is full, nothing else wants it,
  // or lookups have been favoured for STARVE_LIMIT consecutive grants.
  assign upd_win   = fifo_nonempty &&
                     (fifo_full || !i_lkp_valid || (starve_cnt == SW'(STARVE_LIMIT)));
  assign lkp_grant = rst_n && (state == ST_IDLE) && i_lkp_valid && !upd_win;

  // Read-modify-write: the entry read in UPD_RD is on the read bus during UPD_WR.
  assign upd_hit = (i_tbl_rtag == head_pc);

  // New counter and target for the head update, from the entry just read.
  always_comb begin
    new_ctr    = 2'b01;
    new_target = head_target;
    if (upd_hit) begin
      if (head_taken) begin
        new_ctr = (i_tbl_rctr == 2'b11) ? 2'b11 : i_tbl_rctr + 2'b01;
      end else begin
        new_ctr    = (i_tbl_rctr == 2'b00) ? 2'b00 : i_tbl_rctr - 2'b01;
        new_target = i_tbl_rtarget;
      end
    end else begin
      new_ctr = head_taken ? 2'b10 : 2'b01;
    end
  end

  // Next-state selection for the table owner.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:   if (init_idx == '1) state_nxt = ST_IDLE;
      ST_IDLE:   if (upd_win) state_nxt = ST_UPD_RD;
      ST_UPD_RD: state_nxt = ST_UPD_WR;
      ST_UPD_WR: state_nxt = ST_IDLE;
      default:   state_nxt = ST_INIT;
    endcase
  end

  // State, sweep index and starvation counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      init_idx   <= '0;
      starve_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_idx <= init_idx + 1'b1;
      if (((state == ST_IDLE) && upd_win) || !fifo_nonempty) starve_cnt <= '0;
      else if (lkp_grant)                                     starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Table port drive; everything is held at zero while reset is asserted.
  always_comb begin
    o_tbl_en      = 1'b0;
    o_tbl_we      = 1'b0;
    o_tbl_addr    = '0;
    o_tbl_wtag    = '0;
    o_tbl_wtarget = '0;
    o_tbl_wctr    = 2'b00;
    if (rst_n) begin
      case (state)
        ST_INIT: begin
          o_tbl_en   = 1'b1;
          o_tbl_we   = 1'b1;
          o_tbl_addr = init_idx;
          o_tbl_wctr = 2'b01;
        end
        ST_IDLE: begin
          if (lkp_grant) begin
            o_tbl_en   = 1'b1;
            o_tbl_addr = i_lkp_pc[IW+1:2];
          end
        end
        ST_UPD_RD: begin
          o_tbl_en   = 1'b1;
          o_tbl_addr = head_pc[IW+1:2];
        end
        ST_UPD_WR: begin
          o_tbl_en      = 1'b1;
          o_tbl_we      = 1'b1;
          o_tbl_addr    = head_pc[IW+1:2];
          o_tbl_wtag    = head_pc;
          o_tbl_wtarget = new_target;
          o_tbl_wctr    = new_ctr;
        end
        default: ;
      endcase
    end
  end

  // Lookup response stage: remember the granted PC for the tag compare next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      pc_q     <= '0;
    end else begin
      rvalid_q <= lkp_grant;
      if (lkp_grant) pc_q <= i_lkp_pc;
    end
  end

  assign o_lkp_ready  = lkp_grant;
  assign o_lkp_rvalid = rvalid_q;
  assign o_lkp_taken  = rvalid_q && (i_tbl_rtag == pc_q) && i_tbl_rctr[1];
  assign o_lkp_target = !rvalid_q   ? '0 :
                        o_lkp_taken ? i_tbl_rtarget : pc_q + N'(4);
  assign o_init_busy  = !rst_n || (state == ST_INIT);
endmodule

// File: tb/tb_bht_access_ctrl.sv
// tb/tb_bht_access_ctrl.sv - scoreboard bench for bht_access_ctrl with behavioural BHT RAM
module tb_bht_access_ctrl;
  logic        clk;
  logic        rst_n;
  logic        i_lkp_valid;
  logic [31:0] i_lkp_pc;
  logic        o_lkp_ready;
  logic        o_lkp_rvalid;
  logic        o_lkp_taken;
  logic [31:0] o_lkp_target;
  logic        i_upd_valid;
  logic [31:0] i_upd_pc;
  logic [31:0] i_upd_target;
  logic        i_upd_taken;
  logic        o_upd_ready;
  logic        o_init_busy;
  logic        o_tbl_en;
  logic        o_tbl_we;
  logic [7:0]  o_tbl_addr;
  logic [31:0] o_tbl_wtag;
  logic [31:0] o_tbl_wtarget;
  logic [1:0]  o_tbl_wctr;
  logic [31:0] i_tbl_rtag;
  logic [31:0] i_tbl_rtarget;
  logic [1:0]  i_tbl_rctr;

  bht_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_lkp_valid(i_lkp_valid), .i_lkp_pc(i_lkp_pc), .o_lkp_ready(o_lkp_ready),
    .o_lkp_rvalid(o_lkp_rvalid), .o_lkp_taken(o_lkp_taken), .o_lkp_target(o_lkp_target),
    .i_upd_valid(i_upd_valid), .i_upd_pc(i_upd_pc), .i_upd_target(i_upd_target),
    .i_upd_taken(i_upd_taken), .o_upd_ready(o_upd_ready), .o_init_busy(o_init_busy),
    .o_tbl_en(o_tbl_en), .o_tbl_we(o_tbl_we), .o_tbl_addr(o_tbl_addr),
    .o_tbl_wtag(o_tbl_wtag), .o_tbl_wtarget(o_tbl_wtarget), .o_tbl_wctr(o_tbl_wctr),
    .i_tbl_rtag(i_tbl_rtag), .i_tbl_rtarget(i_tbl_rtarget), .i_tbl_rctr(i_tbl_rctr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle read latency.
  logic [31:0] ram_tag [256];
  logic [31:0] ram_tgt [256];
  logic [1:0]  ram_ctr [256];
  always @(posedge clk) begin
    if (o_tbl_en) begin
      if (o_tbl_we) begin
        ram_tag[o_tbl_addr] <= o_tbl_wtag;
        ram_tgt[o_tbl_addr] <= o_tbl_wtarget;
        ram_ctr[o_tbl_addr] <= o_tbl_wctr;
      end else begin
        i_tbl_rtag    <= ram_tag[o_tbl_addr];
        i_tbl_rtarget <= ram_tgt[o_tbl_addr];
        i_tbl_rctr    <= ram_ctr[o_tbl_addr];
      end
    end
  end

  // Reference table contents, updated in push order.
  logic [31:0] ref_tag [256];
  logic [31:0] ref_tgt [256];
  logic [1:0]  ref_ctr [256];
  logic [32:0] exp_q [$];

  int n_checks;
  int n_errors;
  int wr_cnt;
  logic [7:0]  first_wr_addr;
  logic        s_grant, s_rvalid, s_taken, s_en, s_we, s_busy, s_upd_ready, s_upd_acc, s_any;
  logic [31:0] s_target;
  logic [7:0]  s_addr;

  task automatic ref_reset();
    for (int i = 0; i < 256; i++) begin
      ref_tag[i] = '0;
      ref_tgt[i] = '0;
      ref_ctr[i] = 2'b01;
    end
  endtask

  // One clock: sample at negedge, run scoreboard, return just after the posedge.
  task automatic cycle();
    logic [7:0]  idx;
    logic        tk;
    logic [31:0] tg;
    logic [32:0] e;
    @(negedge clk);
    s_grant     = o_lkp_ready;
    s_rvalid    = o_lkp_rvalid;
    s_taken     = o_lkp_taken;
    s_target    = o_lkp_target;
    s_en        = o_tbl_en;
    s_we        = o_tbl_we;
    s_addr      = o_tbl_addr;
    s_busy      = o_init_busy;
    s_upd_ready = o_upd_ready;
    s_upd_acc   = o_upd_ready && i_upd_valid;
    s_any = |{o_lkp_ready, o_lkp_rvalid, o_lkp_taken, o_lkp_target, o_upd_ready, o_tbl_en,
              o_tbl_we, o_tbl_addr, o_tbl_wtag, o_tbl_wtarget, o_tbl_wctr};
    if (o_tbl_en && o_tbl_we) begin
      if (wr_cnt == 0) first_wr_addr = o_tbl_addr;
      wr_cnt++;
    end
    if (o_lkp_ready && i_lkp_valid) begin
      idx = i_lkp_pc[9:2];
      tk  = (ref_tag[idx] == i_lkp_pc) && ref_ctr[idx][1];
      tg  = tk ? ref_tgt[idx] : i_lkp_pc + 32'd4;
      exp_q.push_back({tk, tg});
    end
    if (o_lkp_rvalid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: rvalid with no outstanding grant, got taken=%0b target=%h",
                 o_lkp_taken, o_lkp_target);
      end else begin
        e = exp_q.pop_front();
        if ({o_lkp_taken, o_lkp_target} !== e) begin
          n_errors++;
          $display("FAIL sb_lookup: got taken=%0b target=%h, expected taken=%0b target=%h",
                   o_lkp_taken, o_lkp_target, e[32], e[31:0]);
        end
      end
    end
    if (s_upd_acc) begin
      idx = i_upd_pc[9:2];
      if (ref_tag[idx] == i_upd_pc) begin
        if (i_upd_taken) begin
          ref_ctr[idx] = (ref_ctr[idx] == 2'b11) ? 2'b11 : ref_ctr[idx] + 2'b01;
          ref_tgt[idx] = i_upd_target;
        end else begin
          ref_ctr[idx] = (ref_ctr[idx] == 2'b00) ? 2'b00 : ref_ctr[idx] - 2'b01;
        end
      end else begin
        ref_tag[idx] = i_upd_pc;
        ref_tgt[idx] = i_upd_target;
        ref_ctr[idx] = i_upd_taken ? 2'b10 : 2'b01;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic push_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    logic acc;
    acc = 1'b0;
    i_upd_valid = 1'b1; i_upd_pc = pc; i_upd_target = tgt; i_upd_taken = tk;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (s_upd_acc) begin acc = 1'b1; break; end
    end
    i_upd_valid = 1'b0;
    n_checks++;
    if (acc !== 1'b1) begin
      n_errors++;
      $display("FAIL push_accept: pc=%h not accepted within 50 cycles", pc);
    end
  endtask

  task automatic do_lookup(input logic [31:0] pc, output logic g);
    i_lkp_valid = 1'b1; i_lkp_pc = pc;
    cycle();
    g = s_grant;
    i_lkp_valid = 1'b0;
    cycle();
  endtask

  // Releases reset and measures the sweep while a lookup is held pending.
  task automatic run_init(input string tag);
    int busy, g, bad;
    busy = 0; g = 0; bad = 0;
    wr_cnt = 0;
    rst_n = 1'b1;
    i_lkp_valid = 1'b1; i_lkp_pc = 32'h100;
    for (int k = 0; k < 600; k++) begin
      cycle();
      if (!s_busy) break;
      busy++;
      if (s_grant) g++;
    end
    i_lkp_valid = 1'b0;
    cycle();
    for (int i = 0; i < 256; i++)
      if (ram_ctr[i] !== 2'b01 || ram_tag[i] !== 32'h0 || ram_tgt[i] !== 32'h0) bad++;
    n_checks++; if (busy != 256) begin n_errors++; $display("FAIL %s busy_cycles: got %0d expected 256", tag, busy); end
    n_checks++; if (wr_cnt != 256) begin n_errors++; $display("FAIL %s init_writes: got %0d expected 256", tag, wr_cnt); end
    n_checks++; if (first_wr_addr !== 8'h00) begin n_errors++; $display("FAIL %s first_addr: got %h expected 00", tag, first_wr_addr); end
    n_checks++; if (g != 0) begin n_errors++; $display("FAIL %s grant_in_init: got %0d expected 0", tag, g); end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL %s init_contents: %0d bad entries, expected 0", tag, bad); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_lkp_valid = 1'b0; i_lkp_pc = '0;
    i_upd_valid = 1'b0; i_upd_pc = '0; i_upd_target = '0; i_upd_taken = 1'b0;
    wait_cycles(2);
    n_checks++;
    if (s_busy !== 1'b1 || s_any !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: busy=%0b any_other=%0b expected busy=1 others=0", s_busy, s_any);
    end
    ref_reset();
    run_init("init");
  endtask

  task automatic test_lookup();
    logic g;
    wait_cycles(3);
    do_lookup(32'h100, g);
    n_checks++;
    if (g !== 1'b1) begin n_errors++; $display("FAIL lkp_grant: got %0b expected 1", g); end
    n_checks++;
    if (s_rvalid !== 1'b1 || s_taken !== 1'b0 || s_target !== 32'h104) begin
      n_errors++;
      $display("FAIL lkp_miss: rvalid=%0b taken=%0b target=%h expected 1 0 00000104", s_rvalid, s_taken, s_target);
    end
  endtask

  task automatic test_update_alloc();
    logic g;
    push_upd(32'h100, 32'h200, 1'b1);
    wait_cycles(20);
    n_checks++;
    if (ram_tag[8'h40] !== 32'h100 || ram_tgt[8'h40] !== 32'h200 || ram_ctr[8'h40] !== 2'b10) begin
      n_errors++;
      $display("FAIL alloc_entry: tag=%h tgt=%h ctr=%b expected 100 200 10", ram_tag[8'h40], ram_tgt[8'h40], ram_ctr[8'h40]);
    end
    do_lookup(32'h100, g);
    n_checks++;
    if (s_rvalid !== 1'b1 || s_taken !== 1'b1 || s_target !== 32'h200) begin
      n_errors++;
      $display("FAIL alloc_lookup: rvalid=%0b taken=%0b target=%h expected 1 1 00000200", s_rvalid, s_taken, s_target);
    end
  endtask

  task automatic test_saturate();
    logic g;
    for (int i = 0; i < 4; i++) push_upd(32'h100, 32'h200, 1'b1);
    wait_cycles(20);
    n_checks++;
    if (ram_ctr[8'h40] !== 2'b11) begin n_errors++; $display("FAIL sat_up: ctr=%b expected 11", ram_ctr[8'h40]); end
    for (int i = 0; i < 3; i++) push_upd(32'h100, 32'h999, 1'b0);
    wait_cycles(20);
    n_checks++;
    if (ram_ctr[8'h40] !== 2'b00 || ram_tgt[8'h40] !== 32'h200) begin
      n_errors++;
      $display("FAIL sat_down: ctr=%b tgt=%h expected 00 00000200", ram_ctr[8'h40], ram_tgt[8'h40]);
    end
    push_upd(32'h100, 32'h999, 1'b0);
    wait_cycles(20);
    n_checks++;
    if (ram_ctr[8'h40] !== 2'b00) begin n_errors++; $display("FAIL sat_floor: ctr=%b expected 00", ram_ctr[8'h40]); end
    do_lookup(32'h100, g);
    n_checks++;
    if (s_taken !== 1'b0 || s_target !== 32'h104) begin
      n_errors++;
      $display("FAIL snt_lookup: taken=%0b target=%h expected 0 00000104", s_taken, s_target);
    end
  endtask

  task automatic test_starve();
    int n, stall;
    i_lkp_valid = 1'b1; i_lkp_pc = 32'h400;
    wait_cycles(2);
    i_upd_valid = 1'b1; i_upd_pc = 32'h100; i_upd_target = 32'h300; i_upd_taken = 1'b1;
    cycle();
    i_upd_valid = 1'b0;
    n_checks++;
    if (s_upd_acc !== 1'b1 || s_grant !== 1'b1) begin
      n_errors++;
      $display("FAIL starve_push: acc=%0b grant=%0b expected 1 1", s_upd_acc, s_grant);
    end
    n = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (!s_grant) break;
      n++;
    end
    stall = 1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (s_grant) break;
      stall++;
    end
    n_checks++;
    if (n != 8) begin n_errors++; $display("FAIL starve_grants: got %0d expected 8", n); end
    n_checks++;
    if (stall != 3) begin n_errors++; $display("FAIL starve_stall: got %0d expected 3", stall); end
  endtask

  task automatic test_full();
    logic g;
    for (int i = 0; i < 4; i++) begin
      i_upd_valid = 1'b1; i_upd_pc = 32'h104 + 32'(4 * i);
      i_upd_target = 32'h900 + 32'(16 * i); i_upd_taken = 1'b1;
      cycle();
      n_checks++;
      if (s_upd_acc !== 1'b1 || s_grant !== 1'b1) begin
        n_errors++;
        $display("FAIL fill_%0d: acc=%0b grant=%0b expected 1 1", i, s_upd_acc, s_grant);
      end
    end
    i_upd_pc = 32'h114; i_upd_target = 32'habc;
    cycle();
    n_checks++;
    if (s_upd_ready !== 1'b0 || s_upd_acc !== 1'b0 || s_grant !== 1'b0) begin
      n_errors++;
      $display("FAIL full_wins: upd_ready=%0b acc=%0b grant=%0b expected 0 0 0", s_upd_ready, s_upd_acc, s_grant);
    end
    i_upd_valid = 1'b0;
    cycle();
    n_checks++;
    if (s_en !== 1'b1 || s_we !== 1'b0 || s_addr !== 8'h41) begin
      n_errors++;
      $display("FAIL full_rd: en=%0b we=%0b addr=%h expected 1 0 41", s_en, s_we, s_addr);
    end
    i_lkp_valid = 1'b0;
    wait_cycles(20);
    do_lookup(32'h108, g);
    n_checks++;
    if (s_taken !== 1'b1 || s_target !== 32'h910) begin
      n_errors++;
      $display("FAIL full_lookup: taken=%0b target=%h expected 1 00000910", s_taken, s_target);
    end
    do_lookup(32'h114, g);
    n_checks++;
    if (s_taken !== 1'b0 || s_target !== 32'h118) begin
      n_errors++;
      $display("FAIL full_dropped: taken=%0b target=%h expected 0 00000118", s_taken, s_target);
    end
  endtask

  task automatic test_reset_mid();
    int wr0;
    i_lkp_valid = 1'b1; i_lkp_pc = 32'h400;
    for (int i = 0; i < 3; i++) begin
      i_upd_valid = 1'b1; i_upd_pc = 32'h200 + 32'(4 * i);
      i_upd_target = 32'h700; i_upd_taken = 1'b1;
      cycle();
      n_checks++;
      if (s_upd_acc !== 1'b1) begin n_errors++; $display("FAIL mid_push_%0d: acc=%0b expected 1", i, s_upd_acc); end
    end
    i_upd_valid = 1'b0; i_lkp_valid = 1'b0;
    cycle();
    cycle();
    n_checks++;
    if (s_en !== 1'b1 || s_we !== 1'b0 || s_addr !== 8'h80) begin
      n_errors++;
      $display("FAIL mid_upd_rd: en=%0b we=%0b addr=%h expected 1 0 80", s_en, s_we, s_addr);
    end
    rst_n = 1'b0;
    cycle();
    n_checks++;
    if (s_busy !== 1'b1 || s_any !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset_outputs: busy=%0b any_other=%0b expected 1 0", s_busy, s_any);
    end
    cycle();
    ref_reset();
    run_init("reinit");
    wr0 = wr_cnt;
    wait_cycles(8);
    n_checks++;
    if (wr_cnt != wr0 || s_upd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_fifo_empty: extra_writes=%0d upd_ready=%0b expected 0 1", wr_cnt - wr0, s_upd_ready);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    wr_cnt = 0;
    first_wr_addr = '0;
    test_reset();
    test_lookup();
    test_update_alloc();
    test_saturate();
    test_starve();
    test_full();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: %0d lookup responses never arrived", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
